// File: rtl/ariane_pkg.sv
// Shared core types used by the writeback arbiter.
//   TRANS_ID_BITS : width of a scoreboard entry index
//   NR_WB_PORTS   : number of scoreboard write ports
//   exception_t   : exception record travelling with a result
//   wb_entry_t    : one buffered writeback {trans_id, result, ex}
package ariane_pkg;

   localparam int unsigned TRANS_ID_BITS = 3;
   localparam int unsigned NR_WB_PORTS   = 2;

   typedef struct packed {
      logic [63:0] cause;
      logic [63:0] tval;
      logic        valid;
   } exception_t;

   typedef struct packed {
      logic [TRANS_ID_BITS-1:0] trans_id;
      logic [63:0]              result;
      exception_t               ex;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small per-source result FIFO.
//   clk, rst : clock, asynchronous active-high reset
//   flush    : empty the FIFO at the edge; a same-cycle push is discarded
//   push     : enqueue data at the edge
//   pop      : dequeue head at the edge (ignored when empty)
//   data     : entry to enqueue
//   head     : current head entry (valid only when usage != 0)
//   usage    : registered occupancy, 0..DEPTH
//   drop     : push to a full FIFO without a same-cycle pop (input lost)
module wb_fifo #(
   parameter int unsigned DEPTH   = 2,
   parameter type         entry_t = logic
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  entry_t                   data,
   output entry_t                   head,
   output logic [$clog2(DEPTH):0]   usage,
   output logic                     drop
);

   localparam int unsigned AW = $clog2(DEPTH);

   entry_t          mem [DEPTH];
   logic [AW-1:0]   rd_ptr, wr_ptr;
   logic            full, empty, do_push, do_pop;

   assign full  = usage == (AW+1)'(DEPTH);
   assign empty = usage == '0;

   // Popping frees a slot in the same edge, so push-while-full is legal
   // only when a pop happens alongside it.
   assign do_pop  = pop && !empty && !flush;
   assign do_push = push && !flush && (!full || do_pop);
   assign drop    = push && !flush && full && !do_pop;

   assign head = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         usage  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         usage  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   usage <= usage + 1'b1;
            2'b01:   usage <= usage - 1'b1;
            default: ;
         endcase
      end
   end

   // Storage is not reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= data;
   end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: buffers results from NR_SRC functional units in
// per-source FIFOs and drains up to NR_WB_PORTS of them per cycle onto the
// scoreboard write ports using a round-robin search.
//   clk_i, rst_i    : clock, asynchronous active-high reset
//   flush_i         : discard all buffered results (and same-cycle inputs)
//   src_valid_i     : per-source result pulse (no backpressure)
//   src_trans_id_i  : per-source scoreboard entry
//   src_result_i    : per-source result data
//   src_ex_i        : per-source exception
//   src_full_o      : FIFO holds >= FIFO_DEPTH-1 entries (issue must stall)
//   wb_valid_o      : write port valid
//   wb_trans_id_o   : write port scoreboard entry (zero when idle)
//   wb_result_o     : write port data (zero when idle)
//   wb_ex_o         : write port exception (zero when idle)
//   ovf_o           : sticky overflow, set when an input was dropped
module wb_arbiter import ariane_pkg::*; #(
   parameter int unsigned NR_SRC      = 4,
   parameter int unsigned NR_WB_PORTS = ariane_pkg::NR_WB_PORTS,
   parameter int unsigned FIFO_DEPTH  = 2
) (
   input  logic                                       clk_i,
   input  logic                                       rst_i,
   input  logic                                       flush_i,
   input  logic [NR_SRC-1:0]                          src_valid_i,
   input  logic [NR_SRC-1:0][TRANS_ID_BITS-1:0]       src_trans_id_i,
   input  logic [NR_SRC-1:0][63:0]                    src_result_i,
   input  exception_t [NR_SRC-1:0]                    src_ex_i,
   output logic [NR_SRC-1:0]                          src_full_o,
   output logic [NR_WB_PORTS-1:0]                     wb_valid_o,
   output logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]  wb_trans_id_o,
   output logic [NR_WB_PORTS-1:0][63:0]               wb_result_o,
   output exception_t [NR_WB_PORTS-1:0]               wb_ex_o,
   output logic                                       ovf_o
);

   localparam int unsigned SW = (NR_SRC > 1) ? $clog2(NR_SRC) : 1;
   localparam int unsigned PW = (NR_WB_PORTS > 1) ? $clog2(NR_WB_PORTS) : 1;
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   wb_entry_t [NR_SRC-1:0]             in_ent, head;
   logic [NR_SRC-1:0][CW-1:0]          usage;
   logic [NR_SRC-1:0]                  nonempty, grant, drop;
   logic [SW-1:0]                      rr_ptr, rr_next;
   logic [NR_WB_PORTS-1:0]             port_vld;
   logic [NR_WB_PORTS-1:0][SW-1:0]     port_src;

   // ---------------- per-source FIFOs ----------------
   for (genvar s = 0; s < NR_SRC; s++) begin : g_src
      assign in_ent[s] = '{trans_id: src_trans_id_i[s],
                           result:   src_result_i[s],
                           ex:       src_ex_i[s]};
      assign nonempty[s]   = usage[s] != '0;
      // One slot of headroom: a result already in flight when issue sees
      // the flag still has somewhere to land.
      assign src_full_o[s] = usage[s] >= CW'(FIFO_DEPTH - 1);

      wb_fifo #(
         .DEPTH   (FIFO_DEPTH),
         .entry_t (wb_entry_t)
      ) u_fifo (
         .clk   (clk_i),
         .rst   (rst_i),
         .flush (flush_i),
         .push  (src_valid_i[s]),
         .pop   (grant[s]),
         .data  (in_ent[s]),
         .head  (head[s]),
         .usage (usage[s]),
         .drop  (drop[s])
      );
   end

   // ---------------- round-robin grant search ----------------
   // Walk sources starting at rr_ptr; the n-th non-empty one found goes to
   // port n until the ports run out. rr_next follows the last grant.
   logic [SW:0] idx;
   logic [PW:0] n_grant;

   always_comb begin
      grant    = '0;
      port_vld = '0;
      port_src = '0;
      rr_next  = rr_ptr;
      idx      = '0;
      n_grant  = '0;
      for (int k = 0; k < NR_SRC; k++) begin
         idx = {1'b0, rr_ptr} + (SW+1)'(k);
         if (idx >= (SW+1)'(NR_SRC)) idx = idx - (SW+1)'(NR_SRC);
         if (nonempty[idx[SW-1:0]] && n_grant < (PW+1)'(NR_WB_PORTS)) begin
            grant[idx[SW-1:0]]         = 1'b1;
            port_vld[n_grant[PW-1:0]]  = 1'b1;
            port_src[n_grant[PW-1:0]]  = idx[SW-1:0];
            n_grant                    = n_grant + 1'b1;
            rr_next = (idx == (SW+1)'(NR_SRC - 1)) ? '0 : idx[SW-1:0] + 1'b1;
         end
      end
   end

   // ---------------- write ports ----------------
   for (genvar p = 0; p < NR_WB_PORTS; p++) begin : g_port
      wb_entry_t out_ent;
      assign out_ent          = port_vld[p] ? head[port_src[p]] : '0;
      assign wb_valid_o[p]    = port_vld[p];
      assign wb_trans_id_o[p] = out_ent.trans_id;
      assign wb_result_o[p]   = out_ent.result;
      assign wb_ex_o[p]       = out_ent.ex;
   end

   // ---------------- pointer and overflow state ----------------
   // Flush does not touch rr_ptr or ovf_o; drops are already masked by
   // flush inside the FIFOs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rr_ptr <= '0;
         ovf_o  <= 1'b0;
      end else begin
         rr_ptr <= rr_next;
         if (|drop) ovf_o <= 1'b1;
      end
   end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter NR_SRC, default 4, number of result sources: 0=FLU, 1=load, 2=store, 3=FPU.
REQ-002 Parameter NR_WB_PORTS, default 2, number of scoreboard write ports.
REQ-003 Parameter FIFO_DEPTH, default 2, entries per source FIFO; a power of two, at least 2.
REQ-004 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_i  in  1  reset; asynchronous, active-high.
REQ-006 flush_i  in  1  discard all buffered results.
REQ-007 src_valid_i  in  NR_SRC  per-source result valid, single-cycle pulse; sources have no ready.
REQ-008 src_trans_id_i  in  NR_SRC x TRANS_ID_BITS  scoreboard entry per source.
REQ-009 src_result_i  in  NR_SRC x 64  result data per source.
REQ-010 src_ex_i  in  NR_SRC x exception_t  exception per source.
REQ-011 src_full_o  out  NR_SRC  FIFO holds at least FIFO_DEPTH-1 entries; the issue stage uses it to block issue to that source.
REQ-012 wb_valid_o  out  NR_WB_PORTS  write port valid.
REQ-013 wb_trans_id_o  out  NR_WB_PORTS x TRANS_ID_BITS  scoreboard entry per port.
REQ-014 wb_result_o  out  NR_WB_PORTS x 64  data per port.
REQ-015 wb_ex_o  out  NR_WB_PORTS x exception_t  exception per port.
REQ-016 ovf_o  out  1  sticky overflow error flag.

Function
REQ-017 Each source SHALL own a FIFO of FIFO_DEPTH entries; each entry is {trans_id, result, ex}.
REQ-018 A source with src_valid_i=1 SHALL be enqueued at the clock edge.
REQ-019 Write ports SHALL be driven combinationally from FIFO heads only; minimum input-to-writeback latency is 1 cycle, with no input bypass.
REQ-020 Each cycle the arbiter SHALL grant up to NR_WB_PORTS non-empty FIFOs.
REQ-021 Grant search SHALL be round-robin, starting at source rr_ptr and wrapping modulo NR_SRC.
REQ-022 The first grant SHALL go to port 0, the second to port 1; ungranted ports have wb_valid_o=0 and zero data, trans_id and ex.
REQ-023 A granted FIFO SHALL pop its head at the clock edge; at most one pop per FIFO per cycle.
REQ-024 When at least one grant occurs, rr_ptr SHALL become (last granted index + 1) mod NR_SRC; otherwise rr_ptr holds.
REQ-025 Per-source order SHALL be preserved; no ordering between sources is guaranteed.
REQ-026 Simultaneous push and pop on one FIFO SHALL be legal at any occupancy, including full; occupancy is unchanged.
REQ-027 A push to a full FIFO without a same-cycle pop SHALL drop the input and set ovf_o=1, held until reset; FIFO contents are unchanged.
REQ-028 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; full and empty are distinguished by an occupancy counter of width clog2(FIFO_DEPTH)+1.
REQ-029 flush_i=1 SHALL empty all FIFOs at the edge and drop any same-cycle inputs.
REQ-030 During a flush cycle, wb_valid_o SHALL still reflect pre-flush heads; rr_ptr and ovf_o are unaffected.
REQ-031 src_full_o SHALL be derived from the registered occupancy only, with no combinational path from src_valid_i.

Reset
REQ-032 While rst_i=1: all FIFOs empty, rr_ptr=0, ovf_o=0, wb_valid_o=0, src_full_o=0.
REQ-033 rst_i asserted mid-operation SHALL discard all buffered results immediately (asynchronously), with no writeback in that cycle.
REQ-034 Deasserting rst_i SHALL make the block ready for input on the first following edge.

Structure
REQ-035 The struct wb_entry_t {trans_id, result, ex} and the constant NR_WB_PORTS SHALL live in ariane_pkg; exception_t and TRANS_ID_BITS come from ariane_pkg.
REQ-036 Sub-module wb_fifo (parameterised by depth and entry type, with push/pop/flush, head, occupancy) SHALL be instantiated NR_SRC times; the arbitration logic stays in wb_arbiter.

Verification
REQ-037 Reset then src_valid_i=0001, trans_id 3, result 0xDEAD -> next cycle wb_valid_o=01, wb_trans_id_o[0]=3, wb_result_o[0]=0xDEAD; following cycle wb_valid_o=00.
REQ-038 src_valid_i=1111 in one cycle, rr_ptr=0 -> cycle+1 grants sources 0,1 (ports 0,1); cycle+2 grants sources 2,3; rr_ptr then 0.
REQ-039 Load source pushes 3 results on consecutive cycles while the other 3 sources also push every cycle -> load results are written back in push order, and ovf_o stays 0 only if src_full_o is honoured; without honouring it, ovf_o=1 on the dropping cycle and the dropped trans_id never appears.
REQ-040 Load FIFO full (2 entries) and granted while a new load pushes -> occupancy stays 2, ovf_o=0, and all three results appear in order.
REQ-041 Two entries buffered, then flush_i=1 together with src_valid_i=0100 -> that cycle writes back the pre-flush heads, the next cycle wb_valid_o=00, and the flushed trans_ids never appear.
REQ-042 rst_i pulsed asynchronously between edges with 3 buffered entries -> wb_valid_o=0 immediately, no later writeback, ovf_o=0.
